// File: rtl/led_frame_writer_pkg.sv
// Shared types and constants for the LED frame-buffer write path.
// Colour order inside one row is R, G, B; the writer FSM state set is
// kept here so every block names the states the same way.
package led_frame_pkg;

  localparam int NB_COLORS = 3;

  typedef enum logic [1:0] {COLOR_R, COLOR_G, COLOR_B} color_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} writer_state_t;

endpackage

// File: rtl/led_frame_writer_if.sv
// Pixel stream in / frame-buffer write port out for led_frame_writer.
// The slave modport is the writer; the master modport is the host side
// (deserialiser driving the stream and observing the RAM write port).
// With LED_FRAME_DOUBLE_BUFFER_EN defined, w_addr carries an extra MSB
// selecting the write bank.
interface led_frame_writer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);

`ifdef LED_FRAME_DOUBLE_BUFFER_EN
  localparam int W_ADDR_WIDTH = ADDR_WIDTH + 1;
`else
  localparam int W_ADDR_WIDTH = ADDR_WIDTH;
`endif

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_sof;
  logic                    in_ready;
  logic                    w_en;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    frame_done;
  logic                    frame_error;

  modport master (
    output in_data, in_valid, in_sof,
    input  in_ready, w_en, w_addr, w_data, frame_done, frame_error
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output in_ready, w_en, w_addr, w_data, frame_done, frame_error
  );

endinterface

// File: rtl/led_frame_writer_addr_counter.sv
// Nested colour/row/angle counters plus the RAM address accumulator.
// addr = color + 3*angle + 3*NB_ANGLES*row is tracked incrementally:
// +1 per colour, +3*NB_ANGLES-2 per row, and a reload from a running
// 3*angle base when the rows wrap. clear+step together lands on the
// position right after the first byte of a frame.
module led_frame_addr_counter
  import led_frame_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int LED_ROW_WIDTH = 5,
  parameter int NB_ANGLES     = 128
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  step,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES);
  localparam int SUM_WIDTH   = ADDR_WIDTH + 2;
  localparam logic [SUM_WIDTH-1:0]     ROW_STEP   = SUM_WIDTH'(NB_COLORS * NB_ANGLES - (NB_COLORS - 1));
  localparam logic [SUM_WIDTH-1:0]     ANGLE_STEP = SUM_WIDTH'(NB_COLORS);
  localparam logic [ANGLE_WIDTH-1:0]   LAST_ANGLE = ANGLE_WIDTH'(NB_ANGLES - 1);
  localparam logic [LED_ROW_WIDTH-1:0] LAST_ROW   = '1;

  logic [1:0]               color_reg, color_next;
  logic [LED_ROW_WIDTH-1:0] row_reg, row_next;
  logic [ANGLE_WIDTH-1:0]   angle_reg, angle_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]    base_reg, base_next;

  assign addr = addr_reg;
  assign last = (color_reg == COLOR_B) && (row_reg == LAST_ROW) && (angle_reg == LAST_ANGLE);

  // Next position: restart, restart-and-step, or advance colour -> row -> angle.
  always_comb begin
    color_next = color_reg;
    row_next   = row_reg;
    angle_next = angle_reg;
    addr_next  = addr_reg;
    base_next  = base_reg;
    if (clear) begin
      row_next   = '0;
      angle_next = '0;
      base_next  = '0;
      if (step) begin
        color_next = COLOR_G;
        addr_next  = ADDR_WIDTH'(1);
      end else begin
        color_next = COLOR_R;
        addr_next  = '0;
      end
    end else if (step) begin
      if (last) begin
        color_next = COLOR_R;
        row_next   = '0;
        angle_next = '0;
        base_next  = '0;
        addr_next  = '0;
      end else if (color_reg != COLOR_B) begin
        color_next = color_reg + 2'd1;
        addr_next  = ADDR_WIDTH'({2'b00, addr_reg} + SUM_WIDTH'(1));
      end else if (row_reg != LAST_ROW) begin
        color_next = COLOR_R;
        row_next   = row_reg + LED_ROW_WIDTH'(1);
        addr_next  = ADDR_WIDTH'({2'b00, addr_reg} + ROW_STEP);
      end else begin
        color_next = COLOR_R;
        row_next   = '0;
        angle_next = angle_reg + ANGLE_WIDTH'(1);
        base_next  = ADDR_WIDTH'({2'b00, base_reg} + ANGLE_STEP);
        addr_next  = ADDR_WIDTH'({2'b00, base_reg} + ANGLE_STEP);
      end
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      color_reg <= COLOR_R;
      row_reg   <= '0;
      angle_reg <= '0;
      addr_reg  <= '0;
      base_reg  <= '0;
    end else begin
      color_reg <= color_next;
      row_reg   <= row_next;
      angle_reg <= angle_next;
      addr_reg  <= addr_next;
      base_reg  <= base_next;
    end
  end

endmodule

// File: rtl/led_frame_writer.sv
// LED frame-buffer writer: takes an angle-major pixel byte stream and
// writes each byte into the frame RAM at color + 3*angle + 3*NB_ANGLES*row.
// Writes are registered (one cycle after acceptance). An in_sof mid-frame
// aborts the frame (frame_error) and restarts at address 0.
// Optional macro LED_FRAME_DOUBLE_BUFFER_EN adds a bank bit as w_addr MSB,
// flipped after each completed frame.
module led_frame_writer
  import led_frame_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 8,
  parameter int LED_ROW_WIDTH = 5,
  parameter int NB_ANGLES     = 128
) (
  input  logic               clk,
  input  logic               nrst,
  led_frame_writer_if.slave  bus
);

  localparam int NB_LED_ROWS = 2 ** LED_ROW_WIDTH;
  localparam int FRAME_BYTES = NB_COLORS * NB_ANGLES * NB_LED_ROWS;

`ifdef LED_FRAME_DOUBLE_BUFFER_EN
  localparam int W_ADDR_WIDTH = ADDR_WIDTH + 1;
`else
  localparam int W_ADDR_WIDTH = ADDR_WIDTH;
`endif

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  // The highest frame address must be representable in ADDR_WIDTH bits.
  generate
    if (FRAME_BYTES > 2 ** ADDR_WIDTH) begin : g_addr_range_check
      $error("led_frame_writer: frame of %0d bytes does not fit ADDR_WIDTH=%0d", FRAME_BYTES, ADDR_WIDTH);
    end
  endgenerate

  logic [1:0]              state_reg, state_next;
  logic                    in_ready_reg;
  logic                    w_en_reg;
  logic [W_ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic                    frame_done_reg;
  logic                    frame_error_reg;
  logic                    accept;
  logic                    sof_accept;
  logic                    data_accept;
  logic                    ctr_step;
  logic                    ctr_clear;
  logic [ADDR_WIDTH-1:0]   ctr_addr;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    ctr_last;

  // A sof byte is taken in IDLE or WRITE; plain bytes only count inside a frame.
  assign accept      = bus.in_valid && in_ready_reg;
  assign sof_accept  = accept && bus.in_sof;
  assign data_accept = accept && !bus.in_sof && (state_reg == S_WRITE);

  // A sof restarts the counters one step past address 0; the last byte parks them at 0.
  assign ctr_clear = sof_accept || (data_accept && ctr_last);
  assign ctr_step  = sof_accept || (data_accept && !ctr_last);

  led_frame_addr_counter #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LED_ROW_WIDTH (LED_ROW_WIDTH),
    .NB_ANGLES     (NB_ANGLES)
  ) u_addr_counter (
    .clk   (clk),
    .nrst  (nrst),
    .step  (ctr_step),
    .clear (ctr_clear),
    .addr  (ctr_addr),
    .last  (ctr_last)
  );

  assign word_addr = sof_accept ? '0 : ctr_addr;

`ifdef LED_FRAME_DOUBLE_BUFFER_EN
  logic bank_reg;

  assign w_addr_next = {bank_reg, word_addr};

  // Flip the bank only when a frame has fully completed (DONE cycle).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_reg <= 1'b0;
    end else if (state_reg == S_DONE) begin
      bank_reg <= ~bank_reg;
    end
  end
`else
  assign w_addr_next = word_addr;
`endif

  // Frame sequencing: IDLE waits for sof, WRITE runs to the last byte, DONE is a one-cycle pause.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (sof_accept) state_next = S_WRITE;
      S_WRITE: if (data_accept && ctr_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs; the write lands one cycle after acceptance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg       <= S_IDLE;
      in_ready_reg    <= 1'b0;
      w_en_reg        <= 1'b0;
      w_addr_reg      <= '0;
      w_data_reg      <= '0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      in_ready_reg    <= (state_next != S_DONE);
      w_en_reg        <= sof_accept || data_accept;
      frame_done_reg  <= (state_next == S_DONE) && (state_reg == S_WRITE);
      frame_error_reg <= sof_accept && (state_reg == S_WRITE);
      if (sof_accept || data_accept) begin
        w_addr_reg <= w_addr_next;
        w_data_reg <= bus.in_data;
      end
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.w_en        = w_en_reg;
  assign bus.w_addr      = w_addr_reg;
  assign bus.w_data      = w_data_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_error = frame_error_reg;

endmodule

// File: tb/tb_led_frame_writer.sv
// Self-checking bench for led_frame_writer. A byte-position model derives
// every expected write from the frame layout (colour innermost, then row,
// then angle) and is compared against the DUT each cycle; directed literal
// checks pin the model at known addresses. Covers LED_FRAME_DOUBLE_BUFFER_EN
// when the macro is defined.
module tb_led_frame_writer;

  localparam int ADDR_WIDTH    = 14;
  localparam int DATA_WIDTH    = 8;
  localparam int LED_ROW_WIDTH = 5;
  localparam int NB_ANGLES     = 128;
  localparam int NB_ROWS       = 2 ** LED_ROW_WIDTH;
  localparam int FRAME_BYTES   = 3 * NB_ANGLES * NB_ROWS;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
  localparam int WA = ADDR_WIDTH + 1;
`else
  localparam int WA = ADDR_WIDTH;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  led_frame_writer_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  led_frame_writer #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .LED_ROW_WIDTH (LED_ROW_WIDTH),
    .NB_ANGLES     (NB_ANGLES)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs after each clock edge.
  logic          exp_ready = 1'b0;
  logic          exp_w_en  = 1'b0;
  logic [WA-1:0] exp_w_addr = '0;
  logic [7:0]    exp_w_data = '0;
  logic          exp_done  = 1'b0;
  logic          exp_err   = 1'b0;

  // Model state: position of the next byte inside the frame.
  logic m_ready    = 1'b0;
  logic m_in_frame = 1'b0;
  logic m_done_cyc = 1'b0;
  int   m_pos      = 0;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
  logic m_bank     = 1'b0;
`endif

  function automatic int addr_of(input int p);
    int c, r, a;
    c = p % 3;
    r = (p / 3) % NB_ROWS;
    a = p / (3 * NB_ROWS);
    return c + 3 * a + 3 * NB_ANGLES * r;
  endfunction

  task automatic model_write(input int a, input logic [7:0] d);
    exp_w_en   = 1'b1;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    exp_w_addr = {m_bank, ADDR_WIDTH'(a)};
`else
    exp_w_addr = ADDR_WIDTH'(a);
`endif
    exp_w_data = d;
  endtask

  // Behavioural model: byte stream -> expected write, pulses and readiness.
  always @(posedge clk or negedge nrst) begin
    logic acc;
    if (!nrst) begin
      m_ready = 0; m_in_frame = 0; m_done_cyc = 0; m_pos = 0;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
      m_bank = 0;
`endif
      exp_ready = 0; exp_w_en = 0; exp_w_addr = '0; exp_w_data = '0; exp_done = 0; exp_err = 0;
    end else begin
      acc = bus.in_valid && m_ready;
      exp_w_en = 0; exp_done = 0; exp_err = 0;
      if (m_done_cyc) begin
        m_done_cyc = 0;
        m_ready    = 1;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        m_bank     = ~m_bank;
`endif
      end else begin
        m_ready = 1;
        if (acc && bus.in_sof) begin
          exp_err = m_in_frame;
          model_write(0, bus.in_data);
          m_pos = 1;
          m_in_frame = 1;
        end else if (acc && m_in_frame) begin
          model_write(addr_of(m_pos), bus.in_data);
          if (m_pos == FRAME_BYTES - 1) begin
            m_in_frame = 0; m_pos = 0; exp_done = 1; m_ready = 0; m_done_cyc = 1;
          end else begin
            m_pos++;
          end
        end
      end
      exp_ready = m_ready;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic ok;
    ok = (bus.in_ready === exp_ready) && (bus.w_en === exp_w_en) &&
         (bus.frame_done === exp_done) && (bus.frame_error === exp_err);
    if (exp_w_en || !nrst)
      ok = ok && (bus.w_addr === exp_w_addr) && (bus.w_data === exp_w_data);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_compare @%0t: dut rdy=%b wen=%b addr=%0d data=%02h done=%b err=%b, model rdy=%b wen=%b addr=%0d data=%02h done=%b err=%b",
               $time, bus.in_ready, bus.w_en, bus.w_addr, bus.w_data, bus.frame_done, bus.frame_error,
               exp_ready, exp_w_en, exp_w_addr, exp_w_data, exp_done, exp_err);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one byte from a negedge, hold it until accepted, return at the
  // negedge after the accepting edge (write outputs visible there).
  task automatic send(input logic [7:0] d, input logic sof);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n == 16) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] low_addr();
    return 32'(bus.w_addr[ADDR_WIDTH-1:0]);
  endfunction

  // Bytes 1..stop-1 of a frame (after its sof byte), with optional random gaps.
  task automatic run_frame(input bit gaps, input int stop);
    for (int p = 1; p < stop; p++) begin
      if (gaps && $urandom_range(0, 7) == 0) gap($urandom_range(1, 3));
      send(8'(p * 7 + 3), 1'b0);
      if (p >= 3 && p <= 5) check($sformatf("row1_addr_b%0d", p + 1), low_addr(), 32'(384 + p - 3));
      if (p == 96) check("angle1_addr", low_addr(), 32'd3);
      if (p == FRAME_BYTES - 1) begin
        check("last_addr", low_addr(), 32'd12287);
        check("last_wen", 32'(bus.w_en), 32'd1);
        check("last_done", 32'(bus.frame_done), 32'd1);
        check("last_ready", 32'(bus.in_ready), 32'd0);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 0);
    check("rst_wen", 32'(bus.w_en), 0);
    check("rst_addr", 32'(bus.w_addr), 0);
    check("rst_data", 32'(bus.w_data), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    check("rst_err", 32'(bus.frame_error), 0);
    nrst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 1);
    $display("[TB] reset state checked");

    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("idle_drop_wen", 32'(bus.w_en), 0);
    check("idle_drop_err", 32'(bus.frame_error), 0);
    $display("[TB] idle non-sof bytes dropped");

    send(8'hA5, 1'b1);
    check("sof_wen", 32'(bus.w_en), 1);
    check("sof_addr", 32'(bus.w_addr), 0);
    check("sof_data", 32'(bus.w_data), 32'h A5);
    check("sof_ready", 32'(bus.in_ready), 1);
    run_frame(1'b0, FRAME_BYTES);
    gap(1);
    check("ready_after_done", 32'(bus.in_ready), 1);
    $display("[TB] frame 1 (gap-free) written");

    send(8'h5A, 1'b1);
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    check("frame2_bank", 32'(bus.w_addr[ADDR_WIDTH]), 1);
`endif
    run_frame(1'b1, FRAME_BYTES);
    $display("[TB] frame 2 (random gaps) written");

    send(8'h3C, 1'b1);
    run_frame(1'b0, 500);
    send(8'hC3, 1'b1);
    check("abort_err", 32'(bus.frame_error), 1);
    check("abort_addr", low_addr(), 0);
    check("abort_data", 32'(bus.w_data), 32'h C3);
    check("abort_no_done", 32'(bus.frame_done), 0);
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    check("abort_bank", 32'(bus.w_addr[ADDR_WIDTH]), 0);
`endif
    run_frame(1'b0, FRAME_BYTES);
    $display("[TB] frame 3 aborted at byte 500, restarted frame written");

    send(8'h77, 1'b1);
    run_frame(1'b0, 11);
    #2 nrst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.in_ready), 0);
    check("midrst_wen", 32'(bus.w_en), 0);
    check("midrst_addr", 32'(bus.w_addr), 0);
    check("midrst_data", 32'(bus.w_data), 0);
    check("midrst_done", 32'(bus.frame_done), 0);
    check("midrst_err", 32'(bus.frame_error), 0);
    gap(2);
    nrst = 1'b1;
    gap(1);
    send(8'h88, 1'b1);
    check("post_rst_addr", 32'(bus.w_addr), 0);
    send(8'h89, 1'b0);
    check("post_rst_addr1", 32'(bus.w_addr), 1);
    gap(2);
    $display("[TB] reset mid-frame checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
